// File: rtl/softmax_tile_dispatcher.sv
// Steers a row-interleaved stream of tiles into a bank of row softmax units through a
// one-stage output register, then collects per-row done, reports slice completion and pulses sm_rst_n.
module softmax_tile_dispatcher #(
  parameter  int WIDTH     = 16,
  parameter  int COL       = 64,
  parameter  int TILE_SIZE = 8,
  parameter  int NUM_ROWS  = 4,
  localparam int NUM_TILES = COL / TILE_SIZE,
  localparam int TW        = WIDTH * TILE_SIZE,
  localparam int TIW       = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
  localparam int RW        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [TW-1:0]       in_tile_i,
  output logic [NUM_ROWS-1:0] sm_valid_o,
  input  logic [NUM_ROWS-1:0] sm_ready_i,
  output logic [TW-1:0]       sm_tile_o,
  input  logic [NUM_ROWS-1:0] sm_done_i,
  output logic                sm_rst_n_o,
  output logic                busy_o,
  output logic                slice_done_o,
  output logic                err_o,
  output logic [TIW-1:0]      tile_idx_o,
  output logic [RW-1:0]       row_idx_o
);

  // state  | meaning
  // IDLE   | waiting for start, input closed
  // STREAM | accepting tiles in t0r0, t0r1, ... order
  // DRAIN  | last tile taken; emptying output register, waiting for all row done
  // FLUSH  | one-cycle softmax reset, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_FLUSH} state_e;

  localparam logic [TIW-1:0] TILE_LAST = TIW'(NUM_TILES - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(NUM_ROWS - 1);

  state_e              state_q, state_d;
  logic [TIW-1:0]      tile_idx_q, tile_idx_d;
  logic [RW-1:0]       row_idx_q, row_idx_d;
  logic [RW-1:0]       out_row_q, out_row_d;
  logic                out_full_q, out_full_d;
  logic                out_last_q, out_last_d;
  logic [TW-1:0]       sm_tile_q, sm_tile_d;
  logic [NUM_ROWS-1:0] done_q, done_d;
  logic [NUM_ROWS-1:0] handed_q, handed_d;
  logic                err_q, err_d;
  logic                sm_rst_n_q;
  logic                accept, handoff, last_in;
  logic [NUM_ROWS-1:0] handed_now;

  always_comb begin
    state_d    = state_q;
    tile_idx_d = tile_idx_q;
    row_idx_d  = row_idx_q;
    out_row_d  = out_row_q;
    out_full_d = out_full_q;
    out_last_d = out_last_q;
    sm_tile_d  = sm_tile_q;
    done_d     = done_q;
    err_d      = err_q;
    in_ready_o = 1'b0;

    handoff    = out_full_q && sm_ready_i[out_row_q];
    handed_now = (handoff && out_last_q) ? (NUM_ROWS'(1) << out_row_q) : '0;
    if (state_q == S_STREAM) in_ready_o = !out_full_q || sm_ready_i[out_row_q];
    accept  = in_valid_i && in_ready_o;
    last_in = (tile_idx_q == TILE_LAST) && (row_idx_q == ROW_LAST);

    // a reload on the handoff cycle keeps the register full with no bubble
    if (accept) begin
      sm_tile_d  = in_tile_i;
      out_row_d  = row_idx_q;
      out_last_d = (tile_idx_q == TILE_LAST);
      out_full_d = 1'b1;
    end else if (handoff) begin
      out_full_d = 1'b0;
    end

    handed_d = handed_q | handed_now;
    if (state_q == S_STREAM || state_q == S_DRAIN) begin
      done_d = done_q | sm_done_i;
      if (|(sm_done_i & ~(handed_q | handed_now))) err_d = 1'b1;
    end
    if (state_q == S_DRAIN && in_valid_i) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_STREAM;
          tile_idx_d = '0;
          row_idx_d  = '0;
          done_d     = '0;
          handed_d   = '0;
        end
      end
      S_STREAM: begin
        if (accept) begin
          if (last_in) begin
            state_d = S_DRAIN;
          end else if (row_idx_q == ROW_LAST) begin
            row_idx_d  = '0;
            tile_idx_d = tile_idx_q + 1'b1;
          end else begin
            row_idx_d = row_idx_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!out_full_q && (&done_q)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        state_d    = S_IDLE;
        tile_idx_d = '0;
        row_idx_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tile_idx_q <= '0;
      row_idx_q  <= '0;
      out_row_q  <= '0;
      out_full_q <= 1'b0;
      out_last_q <= 1'b0;
      sm_tile_q  <= '0;
      done_q     <= '0;
      handed_q   <= '0;
      err_q      <= 1'b0;
      sm_rst_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_idx_q <= tile_idx_d;
      row_idx_q  <= row_idx_d;
      out_row_q  <= out_row_d;
      out_full_q <= out_full_d;
      out_last_q <= out_last_d;
      sm_tile_q  <= sm_tile_d;
      done_q     <= done_d;
      handed_q   <= handed_d;
      err_q      <= err_d;
      sm_rst_n_q <= (state_d != S_FLUSH);
    end
  end

  assign sm_valid_o   = out_full_q ? (NUM_ROWS'(1) << out_row_q) : '0;
  assign sm_tile_o    = sm_tile_q;
  assign sm_rst_n_o   = sm_rst_n_q;
  assign busy_o       = (state_q != S_IDLE);
  assign slice_done_o = (state_q == S_DRAIN) && !out_full_q && (&done_q);
  assign err_o        = err_q;
  assign tile_idx_o   = tile_idx_q;
  assign row_idx_o    = row_idx_q;

endmodule

// File: tb/tb_softmax_tile_dispatcher.sv
// Bench for softmax_tile_dispatcher: directed and randomized stimulus checked every
// cycle against a slice-level model (accept count, pending tile, per-row flags).
module tb_softmax_tile_dispatcher;
  localparam int WIDTH = 16, COL = 64, TS = 8, NR = 4;
  localparam int NT = COL / TS, TW = WIDTH * TS, TOTAL = NT * NR;
  localparam int TIW = (NT > 1) ? $clog2(NT) : 1;
  localparam int RW  = (NR > 1) ? $clog2(NR) : 1;
  localparam int PH_IDLE = 0, PH_STREAM = 1, PH_DRAIN = 2, PH_FLUSH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [TW-1:0] in_tile = '0;
  logic [NR-1:0] sm_ready = '1, sm_done = '0;
  logic          in_ready_o, sm_rst_n_o, busy_o, slice_done_o, err_o;
  logic [NR-1:0] sm_valid_o;
  logic [TW-1:0] sm_tile_o;
  logic [TIW-1:0] tile_idx_o;
  logic [RW-1:0]  row_idx_o;

  softmax_tile_dispatcher #(.WIDTH(WIDTH), .COL(COL), .TILE_SIZE(TS), .NUM_ROWS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .in_tile_i(in_tile), .sm_valid_o(sm_valid_o), .sm_ready_i(sm_ready), .sm_tile_o(sm_tile_o),
    .sm_done_i(sm_done), .sm_rst_n_o(sm_rst_n_o), .busy_o(busy_o), .slice_done_o(slice_done_o),
    .err_o(err_o), .tile_idx_o(tile_idx_o), .row_idx_o(row_idx_o));

  int checks = 0, errors = 0, cyc_n = 0;

  // slice-level model
  bit            m_valid = 0, m_live = 0, m_pend = 0, m_err = 0;
  int            m_phase = PH_IDLE, m_n = 0, m_pend_n = 0;
  logic [TW-1:0] m_tile = '0;
  bit [NR-1:0]   m_done = '0, m_hl = '0;
  logic [TW-1:0] sbq[$];

  // observation counters for literal expectations
  int            acc_cnt = 0, first_acc = 0, last_acc = 0, n_sd = 0, n_rstlow = 0, hand_cnt = 0;
  logic [TW-1:0] hand_log[64];
  logic [NR-1:0] hand_row[64];

  // responder knobs
  bit            done_auto = 1, done_rnd = 0;
  bit [NR-1:0]   done_allow = '1, done_sent = '0;

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  bit          e_rdy, e_sd, e_rstn, acc, ho, hol;
  bit [NR-1:0] e_vld, hv;
  int          sat, prow;

  always @(negedge clk) begin
    cyc_n++;
    e_rdy  = (m_phase == PH_STREAM) && (!m_pend || sm_ready[m_pend_n % NR]);
    e_vld  = m_pend ? (NR'(1) << (m_pend_n % NR)) : '0;
    e_sd   = (m_phase == PH_DRAIN) && !m_pend && (&m_done);
    e_rstn = m_live && (m_phase != PH_FLUSH);
    sat    = (m_n >= TOTAL) ? TOTAL - 1 : m_n;
    if (m_valid) begin
      chk("in_ready", TW'(in_ready_o), TW'(e_rdy));
      chk("sm_valid", TW'(sm_valid_o), TW'(e_vld));
      chk("sm_tile", sm_tile_o, m_tile);
      chk("busy", TW'(busy_o), TW'(m_phase != PH_IDLE));
      chk("slice_done", TW'(slice_done_o), TW'(e_sd));
      chk("sm_rst_n", TW'(sm_rst_n_o), TW'(e_rstn));
      chk("err", TW'(err_o), TW'(m_err));
      chk("tile_idx", TW'(tile_idx_o), TW'(sat / NR));
      chk("row_idx", TW'(row_idx_o), TW'(sat % NR));
    end
    if (in_valid && in_ready_o && rst_n) begin
      if (acc_cnt == 0) first_acc = cyc_n;
      last_acc = cyc_n;
      acc_cnt++;
    end
    if (slice_done_o) n_sd++;
    if (m_live && rst_n && !sm_rst_n_o) n_rstlow++;
    if (|(sm_valid_o & sm_ready) && hand_cnt < 64) begin
      hand_log[hand_cnt] = sm_tile_o;
      hand_row[hand_cnt] = sm_valid_o;
      hand_cnt++;
    end

    if (!rst_n) begin
      m_valid = 1; m_live = 0; m_phase = PH_IDLE; m_n = 0; m_pend = 0; m_pend_n = 0;
      m_tile = '0; m_done = '0; m_hl = '0; m_err = 0;
      sbq.delete();
    end else if (m_valid) begin
      acc  = e_rdy && in_valid;
      prow = m_pend_n % NR;
      ho   = m_pend && sm_ready[prow];
      hol  = ho && (m_pend_n / NR == NT - 1);
      hv   = hol ? (NR'(1) << prow) : '0;
      if (ho) begin
        if (sbq.size() == 0) chk("handoff_underflow", TW'(1), TW'(0));
        else chk("handoff_data", sm_tile_o, sbq.pop_front());
      end
      if (m_phase == PH_STREAM || m_phase == PH_DRAIN) begin
        if (|(sm_done & ~(m_hl | hv))) m_err = 1;
        m_done |= sm_done;
      end
      if (m_phase == PH_DRAIN && in_valid) m_err = 1;
      m_hl |= hv;
      if (acc) begin
        m_pend = 1; m_pend_n = m_n; m_tile = in_tile; sbq.push_back(in_tile);
      end else if (ho) begin
        m_pend = 0;
      end
      case (m_phase)
        PH_IDLE:   if (start) begin m_phase = PH_STREAM; m_n = 0; m_done = '0; m_hl = '0; end
        PH_STREAM: if (acc) begin m_n++; if (m_n == TOTAL) m_phase = PH_DRAIN; end
        PH_DRAIN:  if (e_sd) m_phase = PH_FLUSH;
        default:   begin m_phase = PH_IDLE; m_n = 0; end
      endcase
      m_live = 1;
    end
  end

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t = '0;
    for (int i = 0; i < TW / 32; i++) t = (t << 32) | TW'($urandom);
    return t;
  endfunction

  task automatic cyc();
    logic [NR-1:0] f;
    @(posedge clk); #1;
    if (done_auto) begin
      f = m_hl & ~done_sent & done_allow;
      if (done_rnd) f &= NR'($urandom);
      sm_done = f;
      done_sent |= f;
    end
  endtask

  task automatic do_reset();
    in_valid = 0; start = 0; sm_done = '0; sm_ready = '1; rst_n = 0;
    cyc(); cyc();
    rst_n = 1; done_sent = '0;
    cyc();
  endtask

  task automatic do_start();
    start = 1; done_sent = '0;
    cyc();
    start = 0;
  endtask

  task automatic stream_until(input int n_target, input bit rnd);
    int g = 0;
    while (m_phase == PH_STREAM && m_n < n_target && g < 3000) begin
      in_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
      in_tile  = rnd ? rand_tile() : TW'(m_n);
      if (rnd) begin sm_ready = NR'($urandom); start = ($urandom_range(9) == 0); end
      cyc(); g++;
    end
    in_valid = 0; start = 0;
    if (g >= 3000) chk("stream_timeout", TW'(g), TW'(0));
  endtask

  task automatic wait_idle(input bit rnd);
    int g = 0;
    while ((busy_o || m_phase != PH_IDLE) && g < 1000) begin
      sm_ready = rnd ? NR'($urandom) : '1;
      cyc(); g++;
    end
    sm_ready = '1;
    if (g >= 1000) chk("idle_timeout", TW'(g), TW'(0));
  endtask

  task automatic clr_obs();
    acc_cnt = 0; n_sd = 0; n_rstlow = 0; hand_cnt = 0;
  endtask

  initial begin
    logic [NR-1:0] ev;
    do_reset();
    chk("reset_busy", TW'(busy_o), TW'(0));
    chk("reset_sm_rst_n", TW'(sm_rst_n_o), TW'(1));

    // full-rate slice with tile value == index
    clr_obs(); sm_ready = '1; done_auto = 1; done_rnd = 0; done_allow = '1;
    do_start();
    stream_until(TOTAL, 0);
    wait_idle(0);
    chk("t1_accepts", TW'(acc_cnt), TW'(32));
    chk("t1_consecutive", TW'(last_acc - first_acc), TW'(31));
    chk("t1_handoffs", TW'(hand_cnt), TW'(32));
    for (int k = 0; k < 32; k++) begin
      ev = NR'(1) << (k % NR);
      chk("t1_hand_value", hand_log[k], TW'(k));
      chk("t1_hand_row", TW'(hand_row[k]), TW'(ev));
    end
    chk("t1_slice_done_pulses", TW'(n_sd), TW'(1));
    chk("t1_sm_rst_low_cycles", TW'(n_rstlow), TW'(1));

    // backpressure on row 2 while t3r2 is held
    clr_obs();
    do_start();
    stream_until(15, 0);
    sm_ready = 4'b1011; in_valid = 1; in_tile = TW'(15);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", TW'(in_ready_o), TW'(0));
      chk("bp_sm_tile", sm_tile_o, TW'(14));
      chk("bp_sm_valid", TW'(sm_valid_o), TW'(4'b0100));
      cyc();
    end
    sm_ready = '1;
    stream_until(TOTAL, 0);
    wait_idle(0);
    chk("bp_accepts", TW'(acc_cnt), TW'(32));
    chk("bp_handoffs", TW'(hand_cnt), TW'(32));
    chk("bp_slice_done_pulses", TW'(n_sd), TW'(1));

    // withheld done[1] holds the slice in DRAIN
    clr_obs(); done_allow = 4'b1101;
    do_start();
    stream_until(TOTAL, 0);
    repeat (20) cyc();
    chk("wd_busy", TW'(busy_o), TW'(1));
    chk("wd_no_slice_done", TW'(n_sd), TW'(0));
    done_allow = '1;
    wait_idle(0);
    chk("wd_slice_done_pulses", TW'(n_sd), TW'(1));
    chk("wd_sm_rst_low_cycles", TW'(n_rstlow), TW'(1));

    // in_valid while IDLE, start during STREAM
    clr_obs(); in_valid = 1;
    repeat (5) cyc();
    chk("idle_no_accept", TW'(acc_cnt), TW'(0));
    do_start();
    stream_until(5, 0);
    start = 1; in_valid = 1; in_tile = TW'(m_n);
    cyc();
    start = 0;
    stream_until(TOTAL, 0);
    wait_idle(0);
    chk("restart_accepts", TW'(acc_cnt), TW'(32));
    chk("restart_err", TW'(err_o), TW'(0));
    chk("restart_slice_done", TW'(n_sd), TW'(1));

    // early done on row 0 after three of its tiles
    done_auto = 0;
    do_start();
    stream_until(12, 0);
    sm_done = 4'b0001;
    cyc();
    sm_done = '0;
    #1 chk("early_err", TW'(err_o), TW'(1));
    repeat (10) cyc();
    chk("early_err_sticky", TW'(err_o), TW'(1));
    do_reset();
    chk("err_cleared", TW'(err_o), TW'(0));

    // reset after ten tiles, then a fresh slice
    clr_obs(); done_auto = 1;
    do_start();
    stream_until(10, 0);
    rst_n = 0;
    cyc();
    #1;
    chk("mid_rst_busy", TW'(busy_o), TW'(0));
    chk("mid_rst_sm_valid", TW'(sm_valid_o), TW'(0));
    chk("mid_rst_sm_tile", sm_tile_o, TW'(0));
    chk("mid_rst_sm_rst_n", TW'(sm_rst_n_o), TW'(0));
    chk("mid_rst_idx", TW'({tile_idx_o, row_idx_o}), TW'(0));
    rst_n = 1; done_sent = '0;
    cyc();
    chk("mid_rst_no_slice_done", TW'(n_sd), TW'(0));
    clr_obs();
    do_start();
    stream_until(TOTAL, 0);
    wait_idle(0);
    chk("fresh_accepts", TW'(acc_cnt), TW'(32));
    chk("fresh_slice_done", TW'(n_sd), TW'(1));

    // randomized legal slices
    done_rnd = 1;
    for (int s = 0; s < 6; s++) begin
      clr_obs();
      do_start();
      stream_until(TOTAL, 1);
      wait_idle(1);
      chk("rnd_accepts", TW'(acc_cnt), TW'(32));
      chk("rnd_slice_done", TW'(n_sd), TW'(1));
    end

    // unconstrained traffic, including protocol errors and resets
    done_auto = 0;
    for (int i = 0; i < 600; i++) begin
      start    = ($urandom_range(9) == 0);
      in_valid = $urandom_range(1);
      in_tile  = rand_tile();
      sm_ready = NR'($urandom);
      sm_done  = ($urandom_range(7) == 0) ? NR'($urandom) : '0;
      rst_n    = ($urandom_range(149) != 0);
      cyc();
    end
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
